// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2, execute T3-T6.
// Moore strobes decoded from the state register and the returned IR.
module control_sequencer #(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [31:0]      IR,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             ZLOout,
  output logic             ZHIout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             HIin,
  output logic             LOin,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic [OPW-1:0]   alu_op,
  output logic             Run
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t state_q, state_d;
  logic   first_q, first_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_md, is_halt;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign is_alu  = (opcode <= 5'h0B);
  assign is_md   = (opcode == 5'h0F) || (opcode == 5'h10);
  assign is_halt = (opcode == 5'h1B);

  // State and first-T1-cycle flag registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_RST;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  // Next-state logic; the flag marks only the entry cycle of T1.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = mem_ready ? S_T2 : S_T1;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (is_halt)             state_d = S_HALT;
        else if (is_alu || is_md) state_d = S_T4;
        else                     state_d = S_T0;
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = is_md ? S_T6 : S_T0;
      S_T6:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    first_d = (state_d == S_T1) && (state_q != S_T1);
  end

  // Moore strobe decode of the current state.
  always_comb begin
    PCout  = 1'b0;
    MARin  = 1'b0;
    IncPC  = 1'b0;
    Zin    = 1'b0;
    ZLOout = 1'b0;
    ZHIout = 1'b0;
    PCin   = 1'b0;
    Read   = 1'b0;
    MDRin  = 1'b0;
    MDRout = 1'b0;
    IRin   = 1'b0;
    Yin    = 1'b0;
    HIin   = 1'b0;
    LOin   = 1'b0;
    Rin    = '0;
    Rout   = '0;
    alu_op = '0;
    Run    = (state_q != S_RST) && (state_q != S_HALT);
    unique case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Read   = 1'b1;
        MDRin  = 1'b1;
        ZLOout = first_q;
        PCin   = first_q;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (is_alu) begin
          Rout[rb] = 1'b1;
          Yin      = 1'b1;
        end else if (is_md) begin
          Rout[ra] = 1'b1;
          Yin      = 1'b1;
        end
      end
      S_T4: begin
        Zin    = 1'b1;
        alu_op = OPW'(opcode);
        if (is_md) Rout[rb] = 1'b1;
        else       Rout[rc] = 1'b1;
      end
      S_T5: begin
        ZLOout = 1'b1;
        if (is_md) LOin    = 1'b1;
        else       Rin[ra] = 1'b1;
      end
      S_T6: begin
        ZHIout = 1'b1;
        HIin   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer.
// Expected strobe vectors are queued per cycle and popped at negedge.
module tb_control_sequencer;

  typedef struct packed {
    logic        pcout, marin, incpc, zin;
    logic        zloout, zhiout, pcin, read;
    logic        mdrin, mdrout, irin, yin;
    logic        hiin, loin;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
    logic        run;
  } vec_t;

  typedef struct {
    vec_t        exp;
    logic        mr;
    logic        ld;
    logic [31:0] ir;
    string       tag;
  } item_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] IR;
  logic        mem_ready;
  logic        PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin;
  logic        Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_op;
  logic        Run;

  vec_t  act;
  item_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  control_sequencer #(.NREGS(16), .OPW(5)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
    .ZLOout(ZLOout), .ZHIout(ZHIout), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
    .alu_op(alu_op), .Run(Run)
  );

  assign act = {PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin,
                Read, MDRin, MDRout, IRin, Yin, HIin, LOin,
                Rin, Rout, alu_op, Run};

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input vec_t a, input vec_t e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, a, e);
    end
  endtask

  function automatic vec_t zr();
    vec_t v = '0;
    v.run = 1'b1;
    return v;
  endfunction

  task automatic push(input vec_t v, input logic mr, input logic ld,
                      input logic [31:0] ir, input string tag);
    item_t it;
    it.exp = v;
    it.mr  = mr;
    it.ld  = ld;
    it.ir  = ir;
    it.tag = tag;
    sb.push_back(it);
  endtask

  task automatic issue(input logic [31:0] ir, input int stall,
                       input string nm);
    vec_t       v;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = ir[31:27];
    ra = ir[26:23];
    rb = ir[22:19];
    rc = ir[18:15];
    v = zr();
    v.pcout = 1; v.marin = 1; v.incpc = 1; v.zin = 1;
    push(v, 1'b1, 1'b0, ir, {nm, "_T0"});
    for (int i = 0; i <= stall; i++) begin
      v = zr();
      v.read = 1; v.mdrin = 1;
      if (i == 0) begin
        v.zloout = 1; v.pcin = 1;
      end
      push(v, (i == stall), 1'b0, ir, $sformatf("%s_T1_%0d", nm, i));
    end
    v = zr();
    v.mdrout = 1; v.irin = 1;
    push(v, 1'b1, 1'b1, ir, {nm, "_T2"});
    if (op <= 5'h0B) begin
      v = zr(); v.rout = 16'd1 << rb; v.yin = 1;
      push(v, 1'b1, 1'b0, ir, {nm, "_T3"});
      v = zr(); v.rout = 16'd1 << rc; v.zin = 1; v.alu = op;
      push(v, 1'b1, 1'b0, ir, {nm, "_T4"});
      v = zr(); v.rin = 16'd1 << ra; v.zloout = 1;
      push(v, 1'b1, 1'b0, ir, {nm, "_T5"});
    end else if (op == 5'h0F || op == 5'h10) begin
      v = zr(); v.rout = 16'd1 << ra; v.yin = 1;
      push(v, 1'b1, 1'b0, ir, {nm, "_T3"});
      v = zr(); v.rout = 16'd1 << rb; v.zin = 1; v.alu = op;
      push(v, 1'b1, 1'b0, ir, {nm, "_T4"});
      v = zr(); v.zloout = 1; v.loin = 1;
      push(v, 1'b1, 1'b0, ir, {nm, "_T5"});
      v = zr(); v.zhiout = 1; v.hiin = 1;
      push(v, 1'b1, 1'b0, ir, {nm, "_T6"});
    end else begin
      push(zr(), 1'b1, 1'b0, ir, {nm, "_T3"});
      if (op == 5'h1B)
        for (int i = 0; i < 3; i++)
          push('0, 1'b1, 1'b0, ir, $sformatf("%s_HALT%0d", nm, i));
    end
  endtask

  task automatic step();
    item_t it;
    @(negedge Clock);
    it = sb.pop_front();
    chk(it.tag, act, it.exp);
    mem_ready = it.mr;
    if (it.ld) IR = it.ir;
  endtask

  task automatic run_all();
    int budget = 200;
    while (sb.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL budget left=%0d", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input string nm);
    Reset = 1'b1;
    sb.delete();
    @(negedge Clock);
    chk({nm, "_rst1"}, act, '0);
    @(negedge Clock);
    chk({nm, "_rst2"}, act, '0);
    Reset = 1'b0;
    mem_ready = 1'b1;
  endtask

  initial begin
    Reset     = 1'b1;
    IR        = 32'h0;
    mem_ready = 1'b1;
    do_reset("init");
    issue(32'h5891_8000, 0, "rol");
    run_all();
    issue(32'h0000_8000, 3, "stall");
    run_all();
    issue(32'h79A0_0000, 0, "mul");
    run_all();
    issue(32'h8000_0000, 1, "div");
    run_all();
    issue(32'hD000_0000, 0, "nop");
    run_all();
    issue(32'h2A4B_0000, 2, "alu");
    run_all();
    issue(32'hD800_0000, 0, "halt");
    run_all();
    do_reset("hrst");
    issue(32'h0000_0000, 0, "add");
    run_n(5);
    do_reset("mid");
    issue(32'h0000_0000, 0, "re");
    run_all();
    issue(32'hD000_0000, 0, "nop2");
    run_all();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
